// File: rtl/picorv_exec_muldiv.sv
// picorv_exec_muldiv: PCPI co-processor executing the RV M-extension (MUL*/DIV*/REM*).
// Latency: result in DONE XLEN/STEP+1 cycles after operand acceptance, 1 cycle for div-by-zero/overflow.
// Backpressure: result held in DONE until pcpi_wb_valid; any new decode_valid aborts the operation.
module picorv_exec_muldiv #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int STEP = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            decode_valid,
  input  logic [ILEN-1:0] decode_insn,
  input  logic [15:0]     decode_prefix,
  input  logic            pcpi_valid,
  input  logic [ILEN-1:0] pcpi_insn,
  input  logic            pcpi_rs1_valid,
  input  logic            pcpi_rs2_valid,
  input  logic [XLEN-1:0] pcpi_rs1_data,
  input  logic [XLEN-1:0] pcpi_rs2_data,
  output logic            pcpi_ready,
  input  logic            pcpi_wb_valid,
  output logic            pcpi_wb_write,
  output logic [XLEN-1:0] pcpi_wb_data,
  output logic            pcpi_busy
);

  localparam int NCYC = XLEN / STEP;
  localparam int CW   = $clog2(NCYC + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic              pending_q;
  logic [2:0]        f3_q;       // funct3 of the most recently decoded M instruction
  logic [2:0]        op_q;       // funct3 of the operation in flight
  logic              neg_q;      // negate the magnitude result at the end
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;      // mul: product; div: {remainder, quotient/dividend}
  logic [2*XLEN-1:0] opa_q;      // mul: shifted multiplicand magnitude
  logic [XLEN-1:0]   opb_q;      // mul: shifting multiplier; div: divisor magnitude
  logic [XLEN-1:0]   result_q;

  // Inputs that carry no information for this unit are folded away here.
  logic unused_ok;
  assign unused_ok = &{1'b0, pcpi_insn, decode_insn, decode_prefix};

  logic is_muldiv;
  assign is_muldiv = (decode_insn[6:0] == 7'b0110011) && (decode_insn[31:25] == 7'b0000001) &&
                     ((decode_prefix[4:0] != 5'b11111) || (ILEN == 32));

  // Acceptance-time operand preparation: magnitudes, sign of result, short-circuit cases.
  logic            accept;
  logic            a_signed_d, b_signed_d, a_neg_d, b_neg_d, neg_d;
  logic            div_zero_d, div_ovf_d;
  logic [XLEN-1:0] amag_d, bmag_d, special_res_d;

  assign accept     = (state_q == IDLE) && pending_q && pcpi_valid && pcpi_rs1_valid && pcpi_rs2_valid;
  assign a_signed_d = (f3_q == 3'd1) || (f3_q == 3'd2) || (f3_q == 3'd4) || (f3_q == 3'd6);
  assign b_signed_d = (f3_q == 3'd1) || (f3_q == 3'd4) || (f3_q == 3'd6);
  assign a_neg_d    = a_signed_d && pcpi_rs1_data[XLEN-1];
  assign b_neg_d    = b_signed_d && pcpi_rs2_data[XLEN-1];
  assign amag_d     = a_neg_d ? -pcpi_rs1_data : pcpi_rs1_data;
  assign bmag_d     = b_neg_d ? -pcpi_rs2_data : pcpi_rs2_data;
  // Remainder takes the dividend's sign; quotient and products take the xor of both signs.
  assign neg_d      = (f3_q[2] && f3_q[1]) ? a_neg_d : (a_neg_d ^ b_neg_d);
  assign div_zero_d = f3_q[2] && (pcpi_rs2_data == '0);
  assign div_ovf_d  = f3_q[2] && !f3_q[0] && (pcpi_rs1_data == MIN_NEG) && (pcpi_rs2_data == '1);
  assign special_res_d = div_zero_d ? (f3_q[1] ? pcpi_rs1_data : '1)
                                    : (f3_q[1] ? '0 : pcpi_rs1_data);

  // One RUN cycle: STEP shift-add (multiply) or STEP restoring-subtract (divide) iterations.
  logic [2*XLEN-1:0] acc_step, opa_step;
  logic [XLEN-1:0]   opb_step;
  logic              hi;
  always_comb begin
    acc_step = acc_q;
    opa_step = opa_q;
    opb_step = opb_q;
    hi       = 1'b0;
    for (int k = 0; k < STEP; k++) begin
      if (!op_q[2]) begin
        if (opb_step[0]) acc_step = acc_step + opa_step;
        opa_step = opa_step << 1;
        opb_step = opb_step >> 1;
      end else begin
        // Bit shifted out of the remainder keeps the XLEN+1-bit partial remainder exact.
        hi       = acc_step[2*XLEN-1];
        acc_step = acc_step << 1;
        if ({hi, acc_step[2*XLEN-1:XLEN]} >= {1'b0, opb_q}) begin
          acc_step[2*XLEN-1:XLEN] = acc_step[2*XLEN-1:XLEN] - opb_q;
          acc_step[0]             = 1'b1;
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] finalize(input logic [2*XLEN-1:0] acc,
                                                input logic [2:0] op, input logic neg);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r, res;
    p = neg ? -acc : acc;
    q = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op[2]) res = (op == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else        res = op[1] ? r : q;
    return res;
  endfunction

  // Control FSM, decode tracking and datapath registers; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      f3_q      <= 3'd0;
      op_q      <= 3'd0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= f3_q;
            neg_q <= neg_d;
            if (div_zero_d || div_ovf_d) begin
              state_q  <= DONE;
              result_q <= special_res_d;
            end else begin
              state_q <= RUN;
              cnt_q   <= CW'(NCYC);
              acc_q   <= f3_q[2] ? {{XLEN{1'b0}}, amag_d} : '0;
              opa_q   <= {{XLEN{1'b0}}, amag_d};
              opb_q   <= bmag_d;
            end
          end
        end
        RUN: begin
          acc_q <= acc_step;
          opa_q <= opa_step;
          opb_q <= opb_step;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= DONE;
            result_q <= finalize(acc_step, op_q, neg_q);
          end
        end
        DONE: begin
          if (pcpi_ready) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A new decode aborts any operation in flight and re-evaluates pending.
      if (decode_valid) begin
        if (state_q != IDLE) state_q <= IDLE;
        pending_q <= is_muldiv;
        if (is_muldiv) f3_q <= decode_insn[14:12];
      end
    end
  end

  assign pcpi_busy     = (state_q != IDLE);
  assign pcpi_wb_write = (state_q == DONE);
  assign pcpi_wb_data  = (state_q == DONE) ? result_q : '0;
  assign pcpi_ready    = (state_q == DONE) && pcpi_wb_valid;

endmodule

// File: tb/tb_picorv_exec_muldiv.sv
// tb_picorv_exec_muldiv: drives a 32-bit/STEP=1 and a 64-bit/STEP=4 instance in lockstep.
// Latency and results are compared with a plain-arithmetic reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_picorv_exec_muldiv;

  localparam int STEP32 = 1;
  localparam int STEP64 = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        decode_valid;
  logic [31:0] decode_insn;
  logic [15:0] decode_prefix;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        rs1_valid, rs2_valid;
  logic [63:0] rs1_data, rs2_data;
  logic        wbv32, wbv64;
  logic        ready32, wbw32, busy32;
  logic [31:0] wbd32;
  logic        ready64, wbw64, busy64;
  logic [63:0] wbd64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  picorv_exec_muldiv #(.XLEN(32), .ILEN(32), .STEP(STEP32)) u_dut32 (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .decode_insn(decode_insn),
    .decode_prefix(decode_prefix), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1_valid(rs1_valid), .pcpi_rs2_valid(rs2_valid),
    .pcpi_rs1_data(rs1_data[31:0]), .pcpi_rs2_data(rs2_data[31:0]),
    .pcpi_ready(ready32), .pcpi_wb_valid(wbv32), .pcpi_wb_write(wbw32),
    .pcpi_wb_data(wbd32), .pcpi_busy(busy32)
  );

  picorv_exec_muldiv #(.XLEN(64), .ILEN(32), .STEP(STEP64)) u_dut64 (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .decode_insn(decode_insn),
    .decode_prefix(decode_prefix), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1_valid(rs1_valid), .pcpi_rs2_valid(rs2_valid),
    .pcpi_rs1_data(rs1_data), .pcpi_rs2_data(rs2_data),
    .pcpi_ready(ready64), .pcpi_wb_valid(wbv64), .pcpi_wb_write(wbw64),
    .pcpi_wb_data(wbd64), .pcpi_busy(busy64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural M-extension result computed with wide signed/unsigned arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic [63:0] a,
                                            input logic [63:0] b, input int xl);
    logic [63:0] mask, am, bm, minv;
    logic signed [127:0] sa, sb, ua, ub, r;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am   = a & mask;
    bm   = b & mask;
    minv = 64'd1 << (xl - 1);
    ua   = {64'd0, am};
    ub   = {64'd0, bm};
    if (xl == 64) begin
      sa = $signed(am);
      sb = $signed(bm);
    end else begin
      sa = $signed(am[31:0]);
      sb = $signed(bm[31:0]);
    end
    case (f3)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> xl;
      3'd2: r = (sa * ub) >>> xl;
      3'd3: r = (ua * ub) >>> xl;
      3'd4: if (bm == 0) r = '1; else if (am == minv && bm == mask) r = ua; else r = sa / sb;
      3'd5: if (bm == 0) r = '1; else r = ua / ub;
      3'd6: if (bm == 0) r = ua; else if (am == minv && bm == mask) r = '0; else r = sa % sb;
      default: if (bm == 0) r = ua; else r = ua % ub;
    endcase
    return r[63:0] & mask;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [63:0] a,
                                     input logic [63:0] b, input int xl, input int step);
    logic [63:0] mask, am, bm;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am = a & mask;
    bm = b & mask;
    if (f3[2] && (bm == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && am == (64'd1 << (xl - 1)) && bm == mask) return 1;
    return 1 + xl / step;
  endfunction

  // Decode cycle followed by the operand-issue cycle t.
  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    @(posedge clock); #1;
    decode_valid  = 1'b1;
    decode_insn   = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    decode_prefix = 16'($urandom);
    @(posedge clock); #1;
    decode_valid = 1'b0;
    decode_insn  = $urandom;
    pcpi_valid   = 1'b1;
    pcpi_insn    = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    rs1_valid    = 1'b1;
    rs2_valid    = 1'b1;
    rs1_data     = a;
    rs2_data     = b;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp32, input logic [63:0] exp64,
                        input int hold);
    int lat32, lat64, d32, r32, r64;
    bit seen64;
    lat32 = ref_latency(f3, a, b, 32, STEP32);
    lat64 = ref_latency(f3, a, b, 64, STEP64);
    d32 = 0; r32 = 0; r64 = 0; seen64 = 1'b0;
    issue(f3, a, b);
    for (int k = 1; k <= 50; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        // Operand inputs are scrambled after acceptance and must be ignored.
        pcpi_valid = 1'b0;
        rs1_valid  = 1'($urandom);
        rs2_valid  = 1'($urandom);
        rs1_data   = {$urandom, $urandom};
        rs2_data   = {$urandom, $urandom};
      end
      wbv32 = (d32 >= hold);
      @(negedge clock);
      if (wbw32) begin
        if (d32 == 0) check_eq({tag, " lat32"}, 64'(k), 64'(lat32));
        check_eq({tag, " data32"}, {32'd0, wbd32}, {32'd0, exp32[31:0]});
        if (!wbv32) begin
          check_eq({tag, " hold ready32"}, {63'd0, ready32}, 64'd0);
          check_eq({tag, " hold busy32"}, {63'd0, busy32}, 64'd1);
        end
        d32++;
      end
      if (ready32) r32++;
      if (wbw64 && !seen64) begin
        seen64 = 1'b1;
        check_eq({tag, " lat64"}, 64'(k), 64'(lat64));
        check_eq({tag, " data64"}, wbd64, exp64);
      end
      if (ready64) r64++;
    end
    check_eq({tag, " ready32 pulses"}, 64'(r32), 64'd1);
    check_eq({tag, " ready64 pulses"}, 64'(r64), 64'd1);
    check_eq({tag, " idle busy32"}, {63'd0, busy32}, 64'd0);
    check_eq({tag, " idle wb32"}, {31'd0, wbw32, wbd32}, 64'd0);
    check_eq({tag, " idle busy64"}, {63'd0, busy64}, 64'd0);
    check_eq({tag, " idle wbd64"}, wbd64, 64'd0);
    wbv32 = 1'b1;
  endtask

  // MUL started, then killed at t+10 by reset or by decoding an ADD.
  task automatic run_abort(input string tag, input bit use_reset);
    int r, w;
    r = 0; w = 0;
    issue(3'd0, 64'd7, 64'd3);
    for (int k = 1; k <= 45; k++) begin
      @(posedge clock); #1;
      if (k == 1) pcpi_valid = 1'b0;
      if (k == 10) begin
        if (use_reset) reset = 1'b1;
        else begin
          decode_valid = 1'b1;
          decode_insn  = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        end
      end
      if (k == 11) begin
        reset        = 1'b0;
        decode_valid = 1'b0;
      end
      @(negedge clock);
      if (k == 9) check_eq({tag, " running busy32"}, {63'd0, busy32}, 64'd1);
      if (ready32 || ready64) r++;
      if (wbw32 || wbw64) w++;
    end
    check_eq({tag, " ready count"}, 64'(r), 64'd0);
    check_eq({tag, " wb_write count"}, 64'(w), 64'd0);
    check_eq({tag, " busy32"}, {63'd0, busy32}, 64'd0);
    check_eq({tag, " busy64"}, {63'd0, busy64}, 64'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [63:0] a, b;
    reset = 1'b1; decode_valid = 1'b0; decode_insn = '0; decode_prefix = '0;
    pcpi_valid = 1'b0; pcpi_insn = '0; rs1_valid = 1'b0; rs2_valid = 1'b0;
    rs1_data = '0; rs2_data = '0; wbv32 = 1'b1; wbv64 = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("reset outs32", {60'd0, ready32, wbw32, busy32, |wbd32}, 64'd0);
    check_eq("reset outs64", {60'd0, ready64, wbw64, busy64, |wbd64}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_op("MUL",       3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, ref_model(3'd0, 64'h7, 64'hFFFFFFFD, 64), 0);
    run_op("MULH",      3'd1, 64'h80000000, 64'h80000000, 64'h40000000, ref_model(3'd1, 64'h80000000, 64'h80000000, 64), 0);
    run_op("MULHSU",    3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, ref_model(3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64), 0);
    run_op("MULHU",     3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, ref_model(3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64), 0);
    run_op("DIV",       3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, ref_model(3'd4, 64'hFFFFFFF9, 64'h2, 64), 0);
    run_op("REM",       3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, ref_model(3'd6, 64'hFFFFFFF9, 64'h2, 64), 0);
    run_op("DIVU",      3'd5, 64'hFFFFFFF9, 64'h2,        64'h7FFFFFFC, ref_model(3'd5, 64'hFFFFFFF9, 64'h2, 64), 0);
    run_op("DIVU by0",  3'd5, 64'h5,        64'h0,        64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0);
    run_op("REM by0",   3'd6, 64'h5,        64'h0,        64'h5,        64'h5, 0);
    run_op("DIV ovf",   3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, ref_model(3'd4, 64'h80000000, 64'hFFFFFFFF, 64), 0);
    run_op("REM ovf",   3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        ref_model(3'd6, 64'h80000000, 64'hFFFFFFFF, 64), 0);
    run_op("MUL hold",  3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, ref_model(3'd0, 64'h7, 64'hFFFFFFFD, 64), 5);
    run_op("MULHU 64",  3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 0);
    run_abort("abort reset", 1'b1);
    run_abort("abort decode", 1'b0);
    run_op("post abort", 3'd1, 64'hFFFFFFFF80000000, 64'h3, ref_model(3'd1, 64'hFFFFFFFF80000000, 64'h3, 32),
           ref_model(3'd1, 64'hFFFFFFFF80000000, 64'h3, 64), 0);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 64'($urandom_range(0, 200)); b = 64'($urandom_range(1, 15)); end
        2: begin a = 64'hFFFFFFFF80000000; b = '1; end
        3: begin a = 64'h8000000000000000; b = '1; end
        default: ;
      endcase
      run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, ref_model(f3, a, b, 32), ref_model(f3, a, b, 64),
             (i % 6 == 5) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
